maj_net_eval: RTL and testbench
===============================

MAJ_NET_EVAL -- requirements
Module: maj_net_eval

Interface
REQ-001 SHALL have parameter N_IN, default 7, number of primary inputs (2..10).
REQ-002 SHALL have parameter N_GATES, default 8, number of majority-3 gates (1..32).
REQ-003 SHALL derive SEL_W = clog2(1+N_IN+N_GATES) and GA_W = max(1, clog2(N_GATES)).
REQ-004 SHALL have port: clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: cfg_we  input  1  gate-table write strobe.
REQ-007 SHALL have port: cfg_addr  input  GA_W  index of the gate being written.
REQ-008 SHALL have port: cfg_data  input  3*(SEL_W+1)  three operands {inv2,sel2,inv1,sel1,inv0,sel0}, operand 0 in the LSBs.
REQ-009 SHALL have port: in_valid  input  1, in_ready  output  1, in_x  input  N_IN  single-vector request handshake.
REQ-010 SHALL have port: out_valid  output  1, out_ready  input  1, out_y  output  1  single-vector result handshake.
REQ-011 SHALL have port: sweep_start  input  1  starts a truth-table sweep.
REQ-012 SHALL have port: tt_valid  output  1, tt_idx  output  N_IN, tt_bit  output  1  per-vector sweep result.
REQ-013 SHALL have port: sweep_done  output  1  one-cycle pulse after the last sweep vector.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port: cfg_err  output  1  sticky configuration-error flag.

Function
REQ-016 SHALL decode each operand as follows: sel 0 -> constant 0; sel 1..N_IN -> x[sel-1]; sel N_IN+1..N_IN+N_GATES -> w[sel-N_IN-1]. The operand value SHALL be XORed with its inv bit.
REQ-017 SHALL compute gate g as w[g] = MAJ(a,b,c) = ab | ac | bc. The network output SHALL be w[N_GATES-1].
REQ-018 SHALL treat a gate operand referencing w[j] with j >= g, or any sel > N_IN+N_GATES, as constant 0 before inv is applied, and SHALL set cfg_err when that gate is evaluated.
REQ-019 SHALL evaluate exactly one gate per cycle, in ascending order g = 0..N_GATES-1. w[] registers SHALL hold the values from the current vector only.
REQ-020 SHALL implement the FSM states IDLE, EVAL, RESP and SWEEP.
REQ-021 SHALL assert in_ready only in IDLE with sweep_start low.
REQ-022 SHALL capture in_x on the edge where in_valid and in_ready are both high, and SHALL move IDLE -> EVAL on that edge.
REQ-023 SHALL, in EVAL, go to RESP after the gate N_GATES-1 cycle. out_valid SHALL rise exactly N_GATES+1 cycles after the accepting edge.
REQ-024 SHALL, in RESP, hold out_valid and out_y stable until out_ready is high. out_valid and out_ready both high SHALL return the FSM to IDLE, and in_ready SHALL be high the next cycle.
REQ-025 SHALL, when sweep_start is high in IDLE, enter SWEEP with vector index 0. sweep_start SHALL take priority over a simultaneous in_valid, which is not accepted. sweep_start outside IDLE SHALL be ignored.
REQ-026 SHALL, in SWEEP, evaluate vector v over N_GATES cycles, then pulse tt_valid for one cycle with tt_idx = v and tt_bit = f(v), then increment v.
REQ-027 SHALL produce no tt_valid back-pressure. Consecutive tt_valid pulses SHALL be N_GATES cycles apart.
REQ-028 SHALL, after v = 2^N_IN-1 completes, pulse sweep_done the following cycle and return to IDLE. The vector counter SHALL NOT wrap into a second pass.
REQ-029 SHALL accept cfg_we only in IDLE. A cfg_we while busy SHALL be dropped, the table SHALL be unchanged, and cfg_err SHALL be set.
REQ-030 SHALL ignore a cfg_addr >= N_GATES and SHALL set cfg_err for it.
REQ-031 SHALL make a config write in IDLE effective for any evaluation accepted on the next cycle or later.
REQ-032 SHALL clear cfg_err only by rst.

Reset
REQ-033 SHALL, while rst is high at an edge, put the FSM in IDLE, clear all gate-table entries to zero (all operands constant 0, no inversion, so f = 0), clear w[], and clear the vector counter.
REQ-034 SHALL hold in_ready=0, out_valid=0, out_y=0, tt_valid=0, tt_idx=0, tt_bit=0, sweep_done=0, busy=0 and cfg_err=0 during reset. in_ready SHALL be 1 on the first cycle after rst falls.
REQ-035 SHALL abort on rst during EVAL, RESP or SWEEP with no further out_valid, tt_valid or sweep_done pulses.

Verification
REQ-036 Defaults, gate0 = MAJ(x0,x1,x2), gates 1..7 = MAJ(w[g-1],w[g-1],0); in_x=7'b0000011, out_ready=1 -> out_valid rises 9 cycles after accept with out_y=1. Repeat with 7'b0000100 -> out_y=0.
REQ-037 Same config, sweep_start pulse -> 128 tt_valid pulses 8 cycles apart, tt_idx 0..127 in order, tt_bit = MAJ(tt_idx[0],tt_idx[1],tt_idx[2]), then one sweep_done pulse.
REQ-038 gate0 inv0=1 with sel0=0 (constant 1), other operands x0,x1 -> f = x0|x1. Check vectors 0, 1, 2 -> out_y 0, 1, 1.
REQ-039 gate2 operand sel = N_IN+1+5 (forward reference) -> cfg_err=1 after that evaluation and the operand is read as 0. cfg_we during SWEEP -> table unchanged, cfg_err=1.
REQ-040 Hold out_ready=0 for 5 cycles in RESP -> out_valid and out_y stable and in_ready=0. Then out_ready=1 -> in_ready=1 the next cycle.
REQ-041 Assert rst at sweep vector 40 -> no tt_valid or sweep_done afterwards, all outputs zero, and f=0 for every vector until reprogrammed.

Source files
------------

// File: rtl/maj_net_eval.sv
// Configurable network of majority-3 gates, evaluated one gate per cycle.
// Handles single-vector requests and full truth-table sweeps.
module maj_net_eval #(
    parameter  int N_IN    = 7,
    parameter  int N_GATES = 8,
    localparam int SEL_W   = $clog2(1 + N_IN + N_GATES),
    localparam int GA_W    = (N_GATES > 2) ? $clog2(N_GATES) : 1,
    localparam int OP_W    = SEL_W + 1,
    localparam int CFG_W   = 3 * OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [GA_W-1:0]  cfg_addr,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    input  logic             sweep_start,
    output logic             tt_valid,
    output logic [N_IN-1:0]  tt_idx,
    output logic             tt_bit,
    output logic             sweep_done,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_RESP  = 2'd2,
        S_SWEEP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GA_W-1:0]    gate_q, gate_d;
    logic [N_IN:0]      vcnt_q, vcnt_d;
    logic [N_IN-1:0]    x_q, x_d;
    logic [N_GATES-1:0] w_q, w_d;
    logic [CFG_W-1:0]   cfg_q [N_GATES];
    logic [CFG_W-1:0]   cfg_d [N_GATES];
    logic               out_valid_q, out_valid_d;
    logic               out_y_q, out_y_d;
    logic               tt_valid_q, tt_valid_d;
    logic [N_IN-1:0]    tt_idx_q, tt_idx_d;
    logic               tt_bit_q, tt_bit_d;
    logic               sweep_done_q, sweep_done_d;
    logic               busy_q, busy_d;
    logic               cfg_err_q, cfg_err_d;

    logic [CFG_W-1:0]   cur_cfg_s;
    logic [2:0]         op_val_s;
    logic [2:0]         op_err_s;
    logic               gate_val_s;
    logic               gate_err_s;
    logic               last_gate_s;
    logic [(1<<GA_W)-1:0] addr_ok_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Returns {err, value}; forward gate references and unused selects read as 0.
    function automatic logic [1:0] decode_op(
        input logic [SEL_W-1:0]   sel,
        input logic [GA_W-1:0]    gate,
        input logic [N_IN-1:0]    x,
        input logic [N_GATES-1:0] w
    );
        logic val;
        logic err;
        logic hit;
        val = 1'b0;
        err = 1'b0;
        hit = (sel == {SEL_W{1'b0}});
        for (int i = 0; i < N_IN; i++) begin
            val = (sel == SEL_W'(i + 1)) ? x[i] : val;
            hit = (sel == SEL_W'(i + 1)) ? 1'b1 : hit;
        end
        for (int j = 0; j < N_GATES; j++) begin
            val = ((sel == SEL_W'(N_IN + 1 + j)) && (GA_W'(j) < gate)) ? w[j] : val;
            err = ((sel == SEL_W'(N_IN + 1 + j)) && !(GA_W'(j) < gate)) ? 1'b1 : err;
            hit = (sel == SEL_W'(N_IN + 1 + j)) ? 1'b1 : hit;
        end
        err = err | ~hit;
        return {err, val};
    endfunction

    // Table of legal write addresses, built at elaboration.
    always_comb begin
        for (int i = 0; i < (1 << GA_W); i++) begin
            addr_ok_s[i] = (i < N_GATES);
        end
    end

    // Operand decode and majority evaluation for the gate currently selected.
    always_comb begin
        cur_cfg_s = {CFG_W{1'b0}};
        for (int i = 0; i < N_GATES; i++) begin
            cur_cfg_s = (gate_q == GA_W'(i)) ? cfg_q[i] : cur_cfg_s;
        end
        for (int k = 0; k < 3; k++) begin
            logic [1:0] dec;
            dec         = decode_op(cur_cfg_s[k*OP_W +: SEL_W], gate_q, x_q, w_q);
            op_err_s[k] = dec[1];
            op_val_s[k] = dec[0] ^ cur_cfg_s[k*OP_W + SEL_W];
        end
        gate_val_s  = maj3(op_val_s[0], op_val_s[1], op_val_s[2]);
        gate_err_s  = |op_err_s;
        last_gate_s = (gate_q == GA_W'(N_GATES - 1));
    end

    // Next-state logic for the FSM, gate table and all registered outputs.
    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        vcnt_d       = vcnt_q;
        x_d          = x_q;
        w_d          = w_q;
        cfg_d        = cfg_q;
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        tt_valid_d   = 1'b0;
        tt_idx_d     = tt_idx_q;
        tt_bit_d     = tt_bit_q;
        sweep_done_d = 1'b0;
        cfg_err_d    = cfg_err_q;

        // Table writes land only in IDLE; anything else is a configuration error.
        if (cfg_we) begin
            if ((state_q != S_IDLE) || !addr_ok_s[cfg_addr]) begin
                cfg_err_d = 1'b1;
            end else begin
                for (int i = 0; i < N_GATES; i++) begin
                    cfg_d[i] = (cfg_addr == GA_W'(i)) ? cfg_data : cfg_q[i];
                end
            end
        end else begin
            cfg_err_d = cfg_err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    state_d = S_SWEEP;
                    vcnt_d  = {(N_IN+1){1'b0}};
                    gate_d  = {GA_W{1'b0}};
                    x_d     = {N_IN{1'b0}};
                    w_d     = {N_GATES{1'b0}};
                end else if (in_valid) begin
                    state_d = S_EVAL;
                    gate_d  = {GA_W{1'b0}};
                    x_d     = in_x;
                    w_d     = {N_GATES{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EVAL: begin
                for (int i = 0; i < N_GATES; i++) begin
                    w_d[i] = (gate_q == GA_W'(i)) ? gate_val_s : w_q[i];
                end
                cfg_err_d = cfg_err_d | gate_err_s;
                if (last_gate_s) begin
                    state_d = S_RESP;
                end else begin
                    gate_d = gate_q + 1'b1;
                end
            end
            S_RESP: begin
                // One registration cycle before out_valid rises.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_y_d     = w_q[N_GATES-1];
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            S_SWEEP: begin
                // vcnt_q[N_IN] set means every vector has been reported.
                if (vcnt_q[N_IN]) begin
                    sweep_done_d = 1'b1;
                    state_d      = S_IDLE;
                    vcnt_d       = {(N_IN+1){1'b0}};
                end else begin
                    for (int i = 0; i < N_GATES; i++) begin
                        w_d[i] = (gate_q == GA_W'(i)) ? gate_val_s : w_q[i];
                    end
                    cfg_err_d = cfg_err_d | gate_err_s;
                    if (last_gate_s) begin
                        tt_valid_d = 1'b1;
                        tt_idx_d   = vcnt_q[N_IN-1:0];
                        tt_bit_d   = gate_val_s;
                        vcnt_d     = vcnt_q + {{N_IN{1'b0}}, 1'b1};
                        x_d        = vcnt_d[N_IN-1:0];
                        gate_d     = {GA_W{1'b0}};
                        w_d        = {N_GATES{1'b0}};
                    end else begin
                        gate_d = gate_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gate_q       <= {GA_W{1'b0}};
            vcnt_q       <= {(N_IN+1){1'b0}};
            x_q          <= {N_IN{1'b0}};
            w_q          <= {N_GATES{1'b0}};
            for (int i = 0; i < N_GATES; i++) begin
                cfg_q[i] <= {CFG_W{1'b0}};
            end
            out_valid_q  <= 1'b0;
            out_y_q      <= 1'b0;
            tt_valid_q   <= 1'b0;
            tt_idx_q     <= {N_IN{1'b0}};
            tt_bit_q     <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            vcnt_q       <= vcnt_d;
            x_q          <= x_d;
            w_q          <= w_d;
            for (int i = 0; i < N_GATES; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            tt_valid_q   <= tt_valid_d;
            tt_idx_q     <= tt_idx_d;
            tt_bit_q     <= tt_bit_d;
            sweep_done_q <= sweep_done_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // in_ready must drop combinationally when sweep_start or rst is high.
    assign in_ready   = (state_q == S_IDLE) && !sweep_start && !rst;
    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign tt_valid   = tt_valid_q;
    assign tt_idx     = tt_idx_q;
    assign tt_bit     = tt_bit_q;
    assign sweep_done = sweep_done_q;
    assign busy       = busy_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_maj_net_eval.sv
// Randomized bench for maj_net_eval against a gate-by-gate majority-vote
// model of the configured network.
module tb_maj_net_eval;

    localparam int N_IN    = 7;
    localparam int N_GATES = 8;
    localparam int SEL_W   = $clog2(1 + N_IN + N_GATES);
    localparam int GA_W    = (N_GATES > 2) ? $clog2(N_GATES) : 1;
    localparam int CFG_W   = 3 * (SEL_W + 1);
    localparam int NV      = 1 << N_IN;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [GA_W-1:0]  cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_x;
    logic             out_valid;
    logic             out_ready;
    logic             out_y;
    logic             sweep_start;
    logic             tt_valid;
    logic [N_IN-1:0]  tt_idx;
    logic             tt_bit;
    logic             sweep_done;
    logic             busy;
    logic             cfg_err;

    int   tsel [N_GATES][3];
    int   tinv [N_GATES][3];
    int   n_checks;
    int   n_fail;
    logic exp_err;

    maj_net_eval #(.N_IN(N_IN), .N_GATES(N_GATES)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .sweep_start(sweep_start), .tt_valid(tt_valid),
        .tt_idx(tt_idx), .tt_bit(tt_bit), .sweep_done(sweep_done),
        .busy(busy), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: each gate takes a majority vote (count of ones >= 2).
    function automatic logic model_f(input logic [N_IN-1:0] x, output logic err);
        int w [N_GATES];
        int s;
        int v;
        int ones;
        err = 1'b0;
        for (int g = 0; g < N_GATES; g++) begin
            ones = 0;
            for (int k = 0; k < 3; k++) begin
                s = tsel[g][k];
                if (s == 0) v = 0;
                else if (s <= N_IN) v = int'(x[s-1]);
                else if (s <= N_IN + N_GATES && (s - N_IN - 1) < g) v = w[s-N_IN-1];
                else begin v = 0; err = 1'b1; end
                ones += v ^ tinv[g][k];
            end
            w[g] = (ones >= 2) ? 1 : 0;
        end
        return w[N_GATES-1] != 0;
    endfunction

    task automatic clear_model();
        for (int g = 0; g < N_GATES; g++)
            for (int k = 0; k < 3; k++) begin
                tsel[g][k] = 0;
                tinv[g][k] = 0;
            end
    endtask

    task automatic cfg_write(input int g, input int s0, input int i0, input int s1,
                             input int i1, input int s2, input int i2);
        cfg_addr = GA_W'(g);
        cfg_data = {1'(i2), SEL_W'(s2), 1'(i1), SEL_W'(s1), 1'(i0), SEL_W'(s0)};
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        tsel[g][0] = s0; tinv[g][0] = i0;
        tsel[g][1] = s1; tinv[g][1] = i1;
        tsel[g][2] = s2; tinv[g][2] = i2;
    endtask

    // Gates 1..N-1 copy the previous gate: MAJ(w[g-1], w[g-1], 0).
    task automatic program_chain();
        for (int g = 1; g < N_GATES; g++) cfg_write(g, N_IN + g, 0, N_IN + g, 0, 0, 0);
    endtask

    task automatic reset_zero_checks();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_tt_valid", int'(tt_valid), 0);
        check("rst_tt_idx", int'(tt_idx), 0);
        check("rst_tt_bit", int'(tt_bit), 0);
        check("rst_sweep_done", int'(sweep_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        reset_zero_checks();
        tick();
        rst = 1'b0;
        clear_model();
        exp_err = 1'b0;
        #1;
        check("in_ready_after_rst", int'(in_ready), 1);
    endtask

    task automatic run_eval(input logic [N_IN-1:0] x, input int hold);
        logic ey;
        logic ee;
        int   cyc;
        ey = model_f(x, ee);
        if (ee) exp_err = 1'b1;
        in_x      = x;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check("eval_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("eval_latency", cyc, N_GATES + 1);
        check("eval_out_y", int'(out_y), int'(ey));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_y", int'(out_y), int'(ey));
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check("resp_drop", int'(out_valid), 0);
        check("resp_in_ready", int'(in_ready), 1);
        check("eval_cfg_err", int'(cfg_err), int'(exp_err));
    endtask

    task automatic run_sweep(input int cfgwe_at, input int abort_at);
        int   cyc;
        int   idx;
        int   stray;
        logic done;
        logic aborted;
        logic eb;
        logic ee;
        eb = model_f('0, ee);
        if (ee) exp_err = 1'b1;
        in_x        = N_IN'($urandom);
        in_valid    = 1'b1;
        sweep_start = 1'b1;
        cfg_addr    = '0;
        cfg_data    = '0;
        #1;
        check("sweep_prio_in_ready", int'(in_ready), 0);
        tick();
        sweep_start = 1'b0;
        in_valid    = 1'b0;
        check("sweep_busy", int'(busy), 1);
        cyc = 0; idx = 0; done = 1'b0; aborted = 1'b0;
        while (!done && cyc < 3000) begin
            tick();
            cyc++;
            cfg_we = (cyc == cfgwe_at);
            if (tt_valid) begin
                eb = model_f(N_IN'(idx), ee);
                check("tt_idx", int'(tt_idx), idx);
                check("tt_bit", int'(tt_bit), int'(eb));
                check("tt_spacing", cyc, N_GATES * (idx + 1));
                idx++;
                if (idx == abort_at) begin
                    aborted = 1'b1;
                    done    = 1'b1;
                end
            end
            if (sweep_done && !aborted) begin
                check("sweep_done_time", cyc, N_GATES * NV + 1);
                check("sweep_count", idx, NV);
                done = 1'b1;
            end
        end
        cfg_we = 1'b0;
        if (!done) begin
            check("sweep_timeout", cyc, -1);
        end else if (aborted) begin
            rst = 1'b1;
            tick();
            reset_zero_checks();
            tick();
            rst = 1'b0;
            clear_model();
            exp_err = 1'b0;
            #1;
            check("abort_in_ready", int'(in_ready), 1);
            stray = 0;
            repeat (100) begin
                tick();
                if (tt_valid || sweep_done || out_valid) stray++;
            end
            check("abort_quiet", stray, 0);
        end else begin
            if (cfgwe_at > 0) exp_err = 1'b1;
            tick();
            check("sweep_done_pulse", int'(sweep_done), 0);
            check("sweep_idle_busy", int'(busy), 0);
            check("sweep_idle_ready", int'(in_ready), 1);
            check("sweep_no_accept", int'(out_valid), 0);
            check("sweep_cfg_err", int'(cfg_err), int'(exp_err));
        end
    endtask

    initial begin
        int s [3];
        int iv [3];
        n_checks    = 0;
        n_fail      = 0;
        exp_err     = 1'b0;
        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        in_valid    = 1'b0;
        in_x        = '0;
        out_ready   = 1'b1;
        sweep_start = 1'b0;
        clear_model();

        do_reset();
        repeat (3) run_eval(N_IN'($urandom), 0);

        cfg_write(0, 1, 0, 2, 0, 3, 0);
        program_chain();
        run_eval(7'b0000011, 0);
        run_eval(7'b0000100, 0);
        repeat (4) run_eval(N_IN'($urandom), 0);
        run_eval(7'b0000111, 5);
        check("cfg_err_clean", int'(cfg_err), 0);
        run_sweep(100, 0);

        do_reset();
        cfg_write(0, 0, 1, 1, 0, 2, 0);
        program_chain();
        run_eval(7'd0, 0);
        run_eval(7'd1, 0);
        run_eval(7'd2, 0);

        // Random legal tables: operands are constants, inputs or earlier gates.
        repeat (3) begin
            for (int g = 0; g < N_GATES; g++) begin
                for (int k = 0; k < 3; k++) begin
                    int r;
                    r = int'($urandom_range(0, 2));
                    if (r == 0) s[k] = 0;
                    else if (r == 2 && g > 0) s[k] = N_IN + 1 + int'($urandom_range(0, g - 1));
                    else s[k] = int'($urandom_range(1, N_IN));
                    iv[k] = int'($urandom_range(0, 1));
                end
                cfg_write(g, s[0], iv[0], s[1], iv[1], s[2], iv[2]);
            end
            repeat (4) run_eval(N_IN'($urandom), 0);
        end

        do_reset();
        cfg_write(0, 1, 0, 2, 0, 3, 0);
        program_chain();
        cfg_write(2, N_IN + 2, 0, N_IN + 2, 0, N_IN + 1 + 5, 0);
        check("fwd_err_before_eval", int'(cfg_err), 0);
        run_eval(7'b0000011, 0);
        check("fwd_err_set", int'(cfg_err), 1);

        cfg_write(2, N_IN + 2, 0, N_IN + 2, 0, 0, 0);
        run_sweep(0, 40);
        repeat (3) run_eval(N_IN'($urandom), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
